// File: rtl/wb_burst_master.sv
// Wishbone B4 burst master: issues incrementing bursts of up to 2^BLW beats,
// with retry handling, per-beat timeout and error abort.
module wb_burst_master #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int BLW       = 4,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    output logic [aw-1:0]     wb_adr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    input  logic              start,
    input  logic [aw-1:0]     address,
    input  logic [dw/8-1:0]   selection,
    input  logic              write,
    input  logic [BLW-1:0]    burst_len,
    input  logic [dw-1:0]     wr_data,
    output logic              wr_req,
    output logic [dw-1:0]     rd_data,
    output logic              rd_valid,
    output logic              active,
    output logic              done,
    output logic [1:0]        status
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RETRY} state_t;

    state_t          state, state_nxt;
    logic [BLW-1:0]  len, beat;
    logic [TW-1:0]   tmo_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            last_beat;
    logic            accept, advance, acked, reissue, waiting, finish;
    logic [1:0]      fin_status;

    assign last_beat = (beat == len);
    assign wr_req    = wb_ack_i & wb_stb_o & wb_we_o & ~last_beat;
    assign wb_bte_o  = 2'b00;

    always_ff @(posedge wb_clk) begin
        if (wb_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Termination decode; err beats rty beats ack when they arrive together.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        advance    = 1'b0;
        acked      = 1'b0;
        reissue    = 1'b0;
        waiting    = 1'b0;
        finish     = 1'b0;
        fin_status = 2'b00;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (wb_err_i) begin
                    finish     = 1'b1;
                    fin_status = 2'b01;
                end else if (wb_rty_i) begin
                    if (retry_cnt == RW'(MAX_RETRY)) begin
                        finish     = 1'b1;
                        fin_status = 2'b10;
                    end else begin
                        reissue = 1'b1;
                    end
                end else if (wb_ack_i) begin
                    acked = 1'b1;
                    if (last_beat)
                        finish = 1'b1;
                    else
                        advance = 1'b1;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    finish     = 1'b1;
                    fin_status = 2'b11;
                end else begin
                    waiting = 1'b1;
                end
                if (finish)
                    state_nxt = IDLE;
                else if (reissue)
                    state_nxt = RETRY;
            end
            RETRY: state_nxt = BUS;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cti_o  <= 3'b000;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            active    <= 1'b0;
            done      <= 1'b0;
            status    <= 2'b00;
            len       <= '0;
            beat      <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            if (accept) begin
                wb_adr_o  <= address;
                wb_sel_o  <= selection;
                wb_we_o   <= write;
                wb_dat_o  <= wr_data;
                wb_cyc_o  <= 1'b1;
                wb_stb_o  <= 1'b1;
                wb_cti_o  <= (burst_len == '0) ? 3'b000 : 3'b010;
                len       <= burst_len;
                beat      <= '0;
                tmo_cnt   <= '0;
                retry_cnt <= '0;
                active    <= 1'b1;
                status    <= 2'b00;
            end
            if (state == RETRY) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end
            if (reissue) begin
                retry_cnt <= retry_cnt + RW'(1);
                wb_cyc_o  <= 1'b0;
                wb_stb_o  <= 1'b0;
            end
            if (waiting)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (acked && !wb_we_o) begin
                rd_data  <= wb_dat_i;
                rd_valid <= 1'b1;
            end
            // Next beat: address wraps naturally at 2^aw
            if (advance) begin
                wb_adr_o  <= wb_adr_o + aw'(dw / 8);
                beat      <= beat + BLW'(1);
                tmo_cnt   <= '0;
                retry_cnt <= '0;
                wb_cti_o  <= ((beat + BLW'(1)) == len) ? 3'b111 : 3'b010;
                if (wb_we_o)
                    wb_dat_o <= wr_data;
            end
            if (finish) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                wb_cti_o <= 3'b000;
                done     <= 1'b1;
                active   <= 1'b0;
                status   <= fin_status;
            end
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: a scripted slave checks every bus
// termination, a monitor checks read data and completion status.
module tb_wb_burst_master;
    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i, rd_data, address, wr_data;
    logic [3:0]  wb_sel_o, selection, burst_len;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o, status;
    logic        start, write, wr_req, rd_valid, active, done;

    typedef struct {
        int          waits;
        int          kind;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    localparam int K_ACK = 0, K_RTY = 1, K_ERRACK = 2;

    resp_t       resp_q[$];
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    logic [1:0]  done_q[$];

    int n_checks = 0, n_err = 0;
    int rd_cnt = 0, done_cnt = 0, gap_cnt = 0, cyc_cnt = 0, wr_cnt = 0;
    int wr_idx = 0;
    int wait_cnt = 0;
    logic [31:0] wr_base = 32'h0;

    assign wr_data = wr_base + 32'(wr_idx);

    always #5 wb_clk = ~wb_clk;

    wb_burst_master dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .start(start), .address(address), .selection(selection),
        .write(write), .burst_len(burst_len), .wr_data(wr_data),
        .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .active(active), .done(done), .status(status)
    );

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scripted slave: answers each strobe from resp_q and checks the beat it terminates
    always begin : slave
        resp_t r;
        beat_t b;
        @(negedge wb_clk);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (wb_cyc_o && wb_stb_o && resp_q.size() > 0) begin
            if (wait_cnt < resp_q[0].waits) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                r = resp_q.pop_front();
                if (beat_q.size() == 0) begin
                    checkOutput("beat_unexpected", wb_stb_o, 0);
                end else begin
                    b = beat_q.pop_front();
                    checkOutput("beat_adr", wb_adr_o, b.adr);
                    checkOutput("beat_cti", wb_cti_o, b.cti);
                    checkOutput("beat_we", wb_we_o, b.we);
                    checkOutput("beat_sel_bte", {wb_sel_o, wb_bte_o}, {4'hF, 2'b00});
                    if (b.we)
                        checkOutput("beat_dat", wb_dat_o, b.dat);
                end
                wb_dat_i = r.data;
                wb_ack_i = (r.kind == K_ACK) || (r.kind == K_ERRACK);
                wb_rty_i = (r.kind == K_RTY);
                wb_err_i = (r.kind == K_ERRACK);
            end
        end
    end

    always begin : monitor
        @(negedge wb_clk);
        #1;
        if (rd_valid) begin
            rd_cnt++;
            if (rd_q.size() == 0)
                checkOutput("rd_unexpected", rd_valid, 0);
            else
                checkOutput("rd_data", rd_data, rd_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            if (done_q.size() == 0)
                checkOutput("done_unexpected", done, 0);
            else
                checkOutput("done_status", status, done_q.pop_front());
        end
        if (active && !wb_cyc_o)
            gap_cnt++;
        if (wb_cyc_o)
            cyc_cnt++;
    end

    // Show-ahead write source: each wr_req consumes the presented word at the edge
    always begin : wr_source
        logic seen;
        @(negedge wb_clk);
        #1;
        seen = wr_req;
        @(posedge wb_clk);
        #1;
        if (seen) begin
            wr_cnt++;
            wr_idx++;
        end
    end

    task automatic pushBeat(input logic [31:0] adr, input logic [2:0] cti,
                            input logic we, input logic [31:0] dat);
        beat_t b;
        b.adr = adr; b.cti = cti; b.we = we; b.dat = dat;
        beat_q.push_back(b);
    endtask

    task automatic pushResp(input int waits, input int kind, input logic [31:0] data);
        resp_t r;
        r.waits = waits; r.kind = kind; r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic applyStimulus(input logic [31:0] adr, input logic we,
                                 input logic [3:0] len, input logic [31:0] base);
        wr_base   = base;
        wr_idx    = 0;
        address   = adr;
        selection = 4'hF;
        write     = we;
        burst_len = len;
        start     = 1'b1;
        @(posedge wb_clk);
        #1;
        start  = 1'b0;
        wr_idx = 1;
    endtask

    task automatic waitDone(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge wb_clk);
            #2;
            n++;
        end
        if (done_cnt == d0)
            checkOutput("done_timeout", done_cnt, d0 + 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int rd0, gap0, cyc0, wr0, dn0;
        wb_rst = 1'b1;
        start = 1'b0; address = '0; selection = '0; write = 1'b0; burst_len = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
        repeat (3) @(posedge wb_clk);
        #1;
        checkOutput("reset_bus", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
                    wb_stb_o, wb_cti_o, wb_bte_o}, 0);
        checkOutput("reset_user", {rd_data, rd_valid, active, done, status}, 0);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        #2;

        // Single read with two wait states
        rd0 = rd_cnt;
        pushResp(2, K_ACK, 32'hDEADBEEF);
        pushBeat(32'h100, 3'b000, 1'b0, 32'h0);
        rd_q.push_back(32'hDEADBEEF);
        done_q.push_back(2'b00);
        applyStimulus(32'h100, 1'b0, 4'd0, 32'h0);
        waitDone(50);
        checkOutput("single_rd_count", rd_cnt - rd0, 1);

        // 4-beat write issued back-to-back, with a stray start mid-burst
        wr0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            pushResp(0, K_ACK, 32'h0);
            pushBeat(32'h200 + 32'(4 * i), (i == 3) ? 3'b111 : 3'b010, 1'b1,
                     32'hA0000000 + 32'(i));
        end
        done_q.push_back(2'b00);
        applyStimulus(32'h200, 1'b1, 4'd3, 32'hA0000000);
        @(negedge wb_clk);
        start = 1'b1; address = 32'hBAD0; write = 1'b0; burst_len = 4'd0;
        @(negedge wb_clk);
        start = 1'b0;
        waitDone(50);
        checkOutput("wr_req_count", wr_cnt - wr0, 3);

        // Two retries on beat 1 of a read, then ack
        gap0 = gap_cnt; rd0 = rd_cnt;
        pushResp(0, K_ACK, 32'h11111111);
        pushResp(0, K_RTY, 32'h0);
        pushResp(0, K_RTY, 32'h0);
        pushResp(1, K_ACK, 32'h22222222);
        pushBeat(32'h200, 3'b010, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            pushBeat(32'h204, 3'b111, 1'b0, 32'h0);
        rd_q.push_back(32'h11111111);
        rd_q.push_back(32'h22222222);
        done_q.push_back(2'b00);
        applyStimulus(32'h200, 1'b0, 4'd1, 32'h0);
        waitDone(50);
        checkOutput("retry_gap_cycles", gap_cnt - gap0, 2);
        checkOutput("retry_rd_count", rd_cnt - rd0, 2);

        // Retries exhausted: four rty on a single read
        gap0 = gap_cnt; rd0 = rd_cnt;
        for (int i = 0; i < 4; i++) begin
            pushResp(0, K_RTY, 32'h0);
            pushBeat(32'h300, 3'b000, 1'b0, 32'h0);
        end
        done_q.push_back(2'b10);
        applyStimulus(32'h300, 1'b0, 4'd0, 32'h0);
        waitDone(50);
        checkOutput("rty_exhaust_gaps", gap_cnt - gap0, 3);
        checkOutput("rty_exhaust_rd_count", rd_cnt - rd0, 0);

        // err together with ack on beat 2 aborts a 4-beat read
        rd0 = rd_cnt;
        pushResp(0, K_ACK, 32'h33333333);
        pushResp(1, K_ACK, 32'h44444444);
        pushResp(0, K_ERRACK, 32'h55555555);
        for (int i = 0; i < 3; i++)
            pushBeat(32'h400 + 32'(4 * i), 3'b010, 1'b0, 32'h0);
        rd_q.push_back(32'h33333333);
        rd_q.push_back(32'h44444444);
        done_q.push_back(2'b01);
        applyStimulus(32'h400, 1'b0, 4'd3, 32'h0);
        waitDone(50);
        checkOutput("err_rd_count", rd_cnt - rd0, 2);
        checkOutput("err_cyc_low", {wb_cyc_o, wb_stb_o, active}, 3'b000);

        // Timeout: no termination at all
        cyc0 = cyc_cnt;
        done_q.push_back(2'b11);
        applyStimulus(32'h500, 1'b0, 4'd0, 32'h0);
        waitDone(400);
        checkOutput("timeout_cyc_cycles", cyc_cnt - cyc0, 255);
        repeat (3) @(negedge wb_clk);
        #2;
        checkOutput("status_held", status, 2'b11);

        // Reset in the middle of a write burst
        pushResp(0, K_ACK, 32'h0);
        pushBeat(32'h600, 3'b010, 1'b1, 32'hC0000000);
        applyStimulus(32'h600, 1'b1, 4'd3, 32'hC0000000);
        repeat (4) @(negedge wb_clk);
        dn0 = done_cnt;
        wb_rst = 1'b1;
        @(posedge wb_clk);
        #1;
        checkOutput("midreset_bus", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
                    wb_stb_o, wb_cti_o, wb_bte_o}, 0);
        checkOutput("midreset_user", {rd_data, rd_valid, active, done, status}, 0);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        #2;
        checkOutput("midreset_no_done", done_cnt - dn0, 0);
        checkOutput("midreset_beats_left", beat_q.size(), 0);

        // New command after reset
        pushResp(1, K_ACK, 32'h12345678);
        pushBeat(32'h700, 3'b000, 1'b0, 32'h0);
        rd_q.push_back(32'h12345678);
        done_q.push_back(2'b00);
        applyStimulus(32'h700, 1'b0, 4'd0, 32'h0);
        waitDone(50);
        repeat (2) @(negedge wb_clk);
        #2;
        checkOutput("queues_drained", {32'(beat_q.size()), 32'(rd_q.size()),
                    32'(done_q.size()), 32'(resp_q.size())}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameters SHALL be: dw, default 32, data width (multiple of 8).
REQ-002 Parameters SHALL be: aw, default 32, address width.
REQ-003 Parameters SHALL be: BLW, default 4, burst-length field width (max 2^BLW beats).
REQ-004 Parameters SHALL be: TIMEOUT, default 255, max wait cycles per beat.
REQ-005 Parameters SHALL be: MAX_RETRY, default 3, retries allowed per beat.
REQ-006 Ports SHALL be:
- wb_clk  in  1  sole clock; all logic rising-edge.
- wb_rst  in  1  synchronous, active-high reset.
- wb_adr_o  out  aw  byte address.
- wb_dat_o  out  dw  write data.
- wb_sel_o  out  dw/8  byte selects.
- wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  Wishbone controls.
- wb_cti_o  out  3  cycle type.
- wb_bte_o  out  2  burst type.
- wb_dat_i  in  dw  read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  slave terminations.
- start  in  1  command strobe.
- address  in  aw  first-beat address.
- selection  in  dw/8  byte selects, all beats.
- write  in  1  1=write, 0=read.
- burst_len  in  BLW  beats minus one.
- wr_data  in  dw  write data source (show-ahead).
- wr_req  out  1  consume strobe for wr_data.
- rd_data  out  dw  read data.
- rd_valid  out  1  rd_data valid, one cycle per beat.
- active  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 ok, 01 bus error, 10 retries exhausted, 11 timeout; held until next start.

Function
REQ-007 All Wishbone outputs, rd_data, rd_valid, done and status SHALL be registered; wr_req SHALL be combinational.
REQ-008 FSM SHALL have states IDLE, BUS, RETRY.
REQ-009 IDLE: start=1 SHALL latch address, selection, write, burst_len and wr_data (beat 0). Next cycle: cyc=stb=1, active=1, state BUS, status=00.
REQ-010 start SHALL be ignored while active=1.
REQ-011 wb_cti_o SHALL be 000 when burst_len=0; otherwise 010 on all beats but the last and 111 on the last. wb_bte_o SHALL be 00 always.
REQ-012 BUS, ack on non-last beat: wb_adr_o += dw/8 (wraps modulo 2^aw), beat count +1, per-beat retry and timeout counters cleared, cyc/stb stay high.
REQ-013 Write burst: wr_req SHALL equal wb_ack_i & wb_stb_o & wb_we_o & not-last-beat; wr_data SHALL be loaded into wb_dat_o on that edge.
REQ-014 Read: each ack SHALL load rd_data=wb_dat_i and pulse rd_valid the following cycle.
REQ-015 Ack on last beat: cyc/stb/we/cti SHALL clear next cycle; done=1 for one cycle; active=0; state IDLE.
REQ-016 Termination priority SHALL be err > rty > ack when asserted together.
REQ-017 err: abort; cyc/stb clear next cycle; done=1; status=01; no rd_valid for that beat.
REQ-018 rty with retry count < MAX_RETRY: count +1; state RETRY; cyc/stb low exactly one cycle; same beat reissued, address and data unchanged.
REQ-019 rty with retry count = MAX_RETRY: abort as REQ-017 with status=10.
REQ-020 Timeout counter SHALL increment each BUS cycle without termination; reaching TIMEOUT SHALL abort as REQ-017 with status=11.
REQ-021 start and ack SHALL never coincide in effect; back-to-back command SHALL be accepted in the IDLE cycle after done.

Reset
REQ-022 wb_rst=1 at any edge, including mid-burst, SHALL force IDLE and drive every output (wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o, rd_data, rd_valid, active, done, status) to zero next cycle. No done pulse SHALL be generated.

Verification
REQ-023 Single read: addr=0x100, burst_len=0, slave ack after 2 wait states with data 0xDEADBEEF -> cti=000; rd_data=0xDEADBEEF with one rd_valid; done; status=00.
REQ-024 4-beat write: addr=0x200, burst_len=3 -> addresses 0x200/204/208/20C; cti 010,010,010,111; exactly 3 wr_req pulses; done.
REQ-025 rty twice then ack on beat 1 -> two one-cycle cyc gaps; addr 0x204 reissued; status=00. rty four times -> status=10.
REQ-026 err with ack on beat 2 -> abort; rd_valid count=2; status=01. No termination for 255 cycles -> status=11.
REQ-027 wb_rst asserted mid-burst -> all outputs 0 next cycle; no done; new start accepted afterwards.
